kuuga_bram_port_arbiter: RTL and testbench
==========================================

// Module: kuuga_bram_port_arbiter
// PURPOSE
//   Shares one single-port BRAM (xpm_memory_spram, READ_LATENCY 2) between the core's
//   instruction-fetch and data-LSU request ports. Grants at most one access per cycle,
//   drives the BRAM port with a word address, and returns rvalid/rdata to the owner
//   exactly READ_LATENCY cycles after its grant. Sits between kuuga core and a unified memory.
// PARAMETERS
//   ADDR_WIDTH    16  byte-address width of requester ports
//   DATA_WIDTH    32  data width (byte enables = DATA_WIDTH/8)
//   READ_LATENCY  2   BRAM read latency in cycles; range 1..4
// PORTS
//   clk            in   1               single clock for requesters and BRAM port
//   reset          in   1               synchronous, active-high
//   inst_req_i     in   1               fetch request; held with addr until inst_gnt_o
//   inst_addr_i    in   ADDR_WIDTH      fetch byte address
//   inst_gnt_o     out  1               fetch accepted this cycle
//   inst_rvalid_o  out  1               fetch data valid on inst_rdata_o
//   inst_rdata_o   out  DATA_WIDTH      fetch read data
//   data_req_i     in   1               LSU request; held with addr/we/be/wdata until gnt
//   data_addr_i    in   ADDR_WIDTH      LSU byte address
//   data_we_i      in   1               1 = write, 0 = read
//   data_be_i      in   DATA_WIDTH/8    byte enables for writes
//   data_wdata_i   in   DATA_WIDTH      write data
//   data_gnt_o     out  1               LSU request accepted this cycle
//   data_rvalid_o  out  1               LSU response (reads and writes)
//   data_rdata_o   out  DATA_WIDTH      LSU read data
//   bram_en_o      out  1               BRAM enable
//   bram_we_o      out  DATA_WIDTH/8    BRAM byte write enables
//   bram_addr_o    out  ADDR_WIDTH-2    BRAM word address (byte addr >> 2)
//   bram_wdata_o   out  DATA_WIDTH      BRAM write data
//   bram_rddata_i  in   DATA_WIDTH      BRAM read data
//   bram_rst_o     out  1               BRAM output-register reset (= reset)
// BEHAVIOUR
//   - Grant is combinational from req in the same cycle; gnt forced 0 while reset high.
//   - Arbitration: one requester active -> it wins. Both active -> round-robin via
//     registered last_owner; last_owner resets to INST, so first contention goes to DATA.
//     last_owner updates only on a grant. Max wait for either requester: 1 cycle.
//   - On grant: bram_en_o=1, bram_addr_o=addr[ADDR_WIDTH-1:2] of winner (addr[1:0] ignored).
//     bram_we_o = data_be_i if DATA wins and data_we_i=1, else 0 (inst never writes).
//     bram_wdata_o = data_wdata_i. No grant: bram_en_o=0, bram_we_o=0, addr/wdata = 0.
//   - Response pipeline: READ_LATENCY-deep shift register of {valid, owner}; stage 0 loaded
//     on grant, shifts every cycle (no stall). Last stage valid -> owner's rvalid_o=1 for
//     exactly one cycle, READ_LATENCY cycles after the gnt cycle; other rvalid_o=0.
//   - Writes produce data_rvalid_o like reads; data_rdata_o then holds pre-write contents
//     (BRAM read_first) and is don't-care to the LSU.
//   - inst_rdata_o and data_rdata_o both driven from bram_rddata_i; meaningful only with
//     the matching rvalid.
//   - Back-to-back grants every cycle sustained; throughput 1 access/cycle.
//   - Reset (any cycle, incl. mid-flight): pipeline cleared next edge; in-flight accesses
//     produce no rvalid; last_owner=INST. Reset values: all rvalid 0, gnt 0, bram_en_o 0,
//     bram_we_o 0, bram_rst_o 1.
//   - Requester dropping req before gnt: legal, nothing issued; no abort after gnt.
// TESTING
//   1 inst_req only, addr 0x0010 -> inst_gnt same cycle, bram_addr 0x0004, we 0;
//     inst_rvalid exactly 2 cycles later with mem[4].
//   2 data write addr 0x0020 be 4'b1111 wdata 0xDEADBEEF, then read 0x0020 -> bram_we
//     1111 on write cycle; read rvalid+2 returns 0xDEADBEEF; write also gets data_rvalid.
//   3 both req held 6 cycles after reset -> grants D,I,D,I,D,I; rvalids follow +2 with
//     matching owner, never both rvalid in one cycle.
//   4 data_be 4'b0010 wdata 0x0000AB00 onto word 0x11223344 -> readback 0x1122AB44.
//   5 reset asserted 1 cycle after grant -> no rvalid on either port; next contention
//     after release granted to DATA.
//   6 misaligned inst_addr 0x0013 -> bram_addr 0x0004; inst_req dropped before gnt while
//     data wins -> no inst access issued.

Source files
------------

// File: rtl/kuuga_bram_port_arbiter.sv
// Shares one single-port BRAM between the fetch and LSU request ports.
// Round-robin on contention; responses return READ_LATENCY cycles after grant.
module kuuga_bram_port_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    inst_req_i,
  input  logic [ADDR_WIDTH-1:0]   inst_addr_i,
  output logic                    inst_gnt_o,
  output logic                    inst_rvalid_o,
  output logic [DATA_WIDTH-1:0]   inst_rdata_o,
  input  logic                    data_req_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    bram_en_o,
  output logic [DATA_WIDTH/8-1:0] bram_we_o,
  output logic [ADDR_WIDTH-3:0]   bram_addr_o,
  output logic [DATA_WIDTH-1:0]   bram_wdata_o,
  input  logic [DATA_WIDTH-1:0]   bram_rddata_i,
  output logic                    bram_rst_o
);

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  owner_e                  last_owner_q, last_owner_d;
  logic [READ_LATENCY-1:0] pipe_valid_q, pipe_valid_d;
  logic [READ_LATENCY-1:0] pipe_is_data_q, pipe_is_data_d;
  logic                    inst_win, data_win;
  logic                    resp_valid;
  logic                    unused_addr_lsbs;

  // Word addressing drops the byte offset of both requesters.
  assign unused_addr_lsbs = ^{inst_addr_i[1:0], data_addr_i[1:0]};

  always_comb begin
    inst_win = 1'b0;
    data_win = 1'b0;
    if (!reset) begin
      if (inst_req_i && data_req_i) begin
        data_win = (last_owner_q == OWNER_INST);
        inst_win = !data_win;
      end else begin
        inst_win = inst_req_i;
        data_win = data_req_i;
      end
    end
  end

  assign inst_gnt_o = inst_win;
  assign data_gnt_o = data_win;

  always_comb begin
    bram_en_o    = inst_win | data_win;
    bram_we_o    = '0;
    bram_addr_o  = '0;
    bram_wdata_o = '0;
    if (data_win) begin
      bram_addr_o  = data_addr_i[ADDR_WIDTH-1:2];
      bram_wdata_o = data_wdata_i;
      if (data_we_i) begin
        bram_we_o = data_be_i;
      end
    end else if (inst_win) begin
      bram_addr_o  = inst_addr_i[ADDR_WIDTH-1:2];
      bram_wdata_o = data_wdata_i;
    end
  end

  always_comb begin
    last_owner_d = last_owner_q;
    if (data_win) begin
      last_owner_d = OWNER_DATA;
    end else if (inst_win) begin
      last_owner_d = OWNER_INST;
    end
    // Stage 0 takes the current grant; the pipe never stalls.
    pipe_valid_d      = pipe_valid_q << 1;
    pipe_valid_d[0]   = inst_win | data_win;
    pipe_is_data_d    = pipe_is_data_q << 1;
    pipe_is_data_d[0] = data_win;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner_q   <= OWNER_INST;
      pipe_valid_q   <= '0;
      pipe_is_data_q <= '0;
    end else begin
      last_owner_q   <= last_owner_d;
      pipe_valid_q   <= pipe_valid_d;
      pipe_is_data_q <= pipe_is_data_d;
    end
  end

  // Responses are suppressed during reset so in-flight accesses never surface.
  assign resp_valid    = pipe_valid_q[READ_LATENCY-1] & ~reset;
  assign inst_rvalid_o = resp_valid & ~pipe_is_data_q[READ_LATENCY-1];
  assign data_rvalid_o = resp_valid & pipe_is_data_q[READ_LATENCY-1];
  assign inst_rdata_o  = bram_rddata_i;
  assign data_rdata_o  = bram_rddata_i;
  assign bram_rst_o    = reset;

endmodule

// File: tb/tb_kuuga_bram_port_arbiter.sv
// Bench for kuuga_bram_port_arbiter: table vectors, directed corner sequences and
// random traffic, all checked against a transaction-level reference model.
module tb_kuuga_bram_port_arbiter;
  localparam int AW = 16, DW = 32, RL = 2, BW = 4, WAW = 14, DEPTH = 1 << WAW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          inst_req, data_req, data_we;
  logic [AW-1:0] inst_addr, data_addr;
  logic [BW-1:0] data_be;
  logic [DW-1:0] data_wdata;
  logic          inst_gnt_o, inst_rvalid_o, data_gnt_o, data_rvalid_o;
  logic [DW-1:0] inst_rdata_o, data_rdata_o, bram_wdata_o, bram_rddata_i;
  logic          bram_en_o, bram_rst_o;
  logic [BW-1:0] bram_we_o;
  logic [WAW-1:0] bram_addr_o;

  kuuga_bram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)) dut (
    .clk(clk), .reset(reset),
    .inst_req_i(inst_req), .inst_addr_i(inst_addr), .inst_gnt_o(inst_gnt_o),
    .inst_rvalid_o(inst_rvalid_o), .inst_rdata_o(inst_rdata_o),
    .data_req_i(data_req), .data_addr_i(data_addr), .data_we_i(data_we),
    .data_be_i(data_be), .data_wdata_i(data_wdata), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .bram_en_o(bram_en_o), .bram_we_o(bram_we_o), .bram_addr_o(bram_addr_o),
    .bram_wdata_o(bram_wdata_o), .bram_rddata_i(bram_rddata_i), .bram_rst_o(bram_rst_o)
  );

  function automatic logic [31:0] init_word(int i);
    return {16'(i) ^ 16'h5A5A, 16'(i)};
  endfunction

  // Read-first BRAM, two-cycle latency; acts mid-cycle where the port is stable.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd0 = '0, rd1 = '0;
  assign bram_rddata_i = rd1;
  always @(negedge clk) begin
    rd1 = bram_rst_o ? '0 : rd0;
    if (bram_en_o) begin
      rd0 = mem[bram_addr_o];
      for (int b = 0; b < BW; b++)
        if (bram_we_o[b]) mem[bram_addr_o][b*8 +: 8] = bram_wdata_o[b*8 +: 8];
    end
  end

  // Reference model state: expected memory, last winner, outstanding responses.
  typedef struct {
    int          due;
    bit          own_data;
    bit          is_rd;
    logic [31:0] data;
  } rsp_t;
  rsp_t        pq[$];
  logic [31:0] ref_mem [DEPTH];
  bit          ref_last_data;
  int          cyc = 0;

  int checks = 0, errors = 0;
  logic          obs_ig, obs_dg;
  logic [WAW-1:0] obs_addr;
  logic [BW-1:0] obs_we;
  logic [DW-1:0] obs_i_rdata, obs_d_rdata;
  int            obs_i_rv_cyc = -1;
  int            n_irv = 0, n_drv = 0, n_both_rv = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cycle();
    bit eig, edg, eiv, edv, erd;
    logic [WAW-1:0] ea;
    logic [BW-1:0]  ewe;
    logic [DW-1:0]  ewd, edat, w;
    rsp_t e;
    #3;
    eig = 0; edg = 0;
    if (!reset) begin
      if (inst_req && data_req) begin
        if (ref_last_data) eig = 1; else edg = 1;
      end else begin
        eig = inst_req; edg = data_req;
      end
    end
    ea  = eig ? inst_addr[AW-1:2] : (edg ? data_addr[AW-1:2] : '0);
    ewe = (edg && data_we) ? data_be : '0;
    ewd = (eig || edg) ? data_wdata : '0;
    chk("inst_gnt", 64'(inst_gnt_o), 64'(eig));
    chk("data_gnt", 64'(data_gnt_o), 64'(edg));
    chk("bram_en", 64'(bram_en_o), 64'(eig | edg));
    chk("bram_addr", 64'(bram_addr_o), 64'(ea));
    chk("bram_we", 64'(bram_we_o), 64'(ewe));
    chk("bram_wdata", 64'(bram_wdata_o), 64'(ewd));
    chk("bram_rst", 64'(bram_rst_o), 64'(reset));
    eiv = 0; edv = 0; erd = 0; edat = '0;
    if (reset) pq.delete();
    else if (pq.size() > 0 && pq[0].due == cyc) begin
      e = pq.pop_front();
      eiv = !e.own_data; edv = e.own_data; erd = e.is_rd; edat = e.data;
    end
    chk("inst_rvalid", 64'(inst_rvalid_o), 64'(eiv));
    chk("data_rvalid", 64'(data_rvalid_o), 64'(edv));
    if (eiv && erd) chk("inst_rdata", 64'(inst_rdata_o), 64'(edat));
    if (edv && erd) chk("data_rdata", 64'(data_rdata_o), 64'(edat));
    obs_ig = inst_gnt_o; obs_dg = data_gnt_o; obs_addr = bram_addr_o; obs_we = bram_we_o;
    if (inst_rvalid_o === 1'b1) begin
      n_irv++; obs_i_rdata = inst_rdata_o; obs_i_rv_cyc = cyc;
    end
    if (data_rvalid_o === 1'b1) begin
      n_drv++; obs_d_rdata = data_rdata_o;
    end
    if (inst_rvalid_o === 1'b1 && data_rvalid_o === 1'b1) n_both_rv++;
    if (reset) ref_last_data = 0;
    else if (eig || edg) begin
      e.due = cyc + RL; e.own_data = edg; e.is_rd = !(edg && data_we); e.data = ref_mem[ea];
      pq.push_back(e);
      if (edg && data_we) begin
        w = ref_mem[ea];
        for (int b = 0; b < BW; b++) if (data_be[b]) w[b*8 +: 8] = data_wdata[b*8 +: 8];
        ref_mem[ea] = w;
      end
      ref_last_data = edg;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    inst_req = 0; data_req = 0; data_we = 0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic dwrite(input logic [AW-1:0] a, input logic [BW-1:0] be, input logic [DW-1:0] d);
    inst_req = 0; data_req = 1; data_addr = a; data_we = 1; data_be = be; data_wdata = d;
    cycle();
  endtask

  task automatic dread(input logic [AW-1:0] a);
    inst_req = 0; data_req = 1; data_addr = a; data_we = 0; data_be = 4'hF;
    cycle();
  endtask

  typedef struct {
    bit          ireq;
    logic [15:0] iaddr;
    bit          dreq;
    logic [15:0] daddr;
    bit          we;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          ig;
    bit          dg;
    logic [13:0] addr;
    logic [3:0]  bwe;
  } vec_t;
  vec_t vecs[8];

  int g_cyc, base_i, base_d, base_b;
  logic [5:0] iseq, dseq;
  bit got_i, got_d;

  initial begin
    // Applied in order right after reset, so last-owner history is part of each row.
    vecs[0] = '{1, 16'h0010, 0, 16'h0000, 0, 4'h0, 32'h0,        1, 0, 14'h004, 4'h0};
    vecs[1] = '{1, 16'h0013, 1, 16'h0020, 1, 4'hF, 32'hDEADBEEF, 0, 1, 14'h008, 4'hF};
    vecs[2] = '{1, 16'h0013, 1, 16'h0020, 1, 4'hF, 32'hDEADBEEF, 1, 0, 14'h004, 4'h0};
    vecs[3] = '{0, 16'h0000, 1, 16'h0020, 0, 4'hF, 32'h0,        0, 1, 14'h008, 4'h0};
    vecs[4] = '{0, 16'h0000, 0, 16'h0000, 0, 4'h0, 32'h0,        0, 0, 14'h000, 4'h0};
    vecs[5] = '{1, 16'h0100, 1, 16'h0024, 1, 4'h2, 32'h0000AB00, 1, 0, 14'h040, 4'h0};
    vecs[6] = '{1, 16'h0100, 1, 16'h0024, 1, 4'h2, 32'h0000AB00, 0, 1, 14'h009, 4'h2};
    vecs[7] = '{0, 16'h0000, 1, 16'h0003, 0, 4'hF, 32'h0,        0, 1, 14'h000, 4'h0};

    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = init_word(i);
      ref_mem[i] = init_word(i);
    end
    ref_last_data = 0;
    reset = 1; inst_req = 1; data_req = 1; inst_addr = 16'h0010; data_addr = 16'h0020;
    data_we = 1; data_be = 4'hF; data_wdata = 32'h12345678;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cycle();
    chk("reset_gnt", 64'({obs_ig, obs_dg}), 64'(0));
    chk("reset_rvalid_count", 64'(n_irv + n_drv), 64'(0));
    reset = 0;

    // Fetch only: same-cycle grant, response two cycles later with mem[4].
    data_req = 0; data_we = 0; inst_req = 1; inst_addr = 16'h0010;
    g_cyc = cyc;
    cycle();
    chk("t1_gnt", 64'(obs_ig), 64'(1));
    chk("t1_addr", 64'(obs_addr), 64'(14'h004));
    idle(3);
    chk("t1_rvalid_cycle", 64'(obs_i_rv_cyc), 64'(g_cyc + 2));
    chk("t1_rdata", 64'(obs_i_rdata), 64'(init_word(4)));

    // Full write then read back; the write also gets a response.
    base_d = n_drv;
    dwrite(16'h0020, 4'hF, 32'hDEADBEEF);
    chk("t2_bram_we", 64'(obs_we), 64'(4'hF));
    dread(16'h0020);
    idle(3);
    chk("t2_rdata", 64'(obs_d_rdata), 64'(32'hDEADBEEF));
    chk("t2_rvalid_count", 64'(n_drv - base_d), 64'(2));

    // Partial byte write merges into the existing word.
    dwrite(16'h0030, 4'hF, 32'h11223344);
    dwrite(16'h0030, 4'b0010, 32'h0000AB00);
    chk("t4_bram_we", 64'(obs_we), 64'(4'b0010));
    dread(16'h0030);
    idle(3);
    chk("t4_rdata", 64'(obs_d_rdata), 64'(32'h1122AB44));

    // Sustained contention after reset alternates D,I,D,I,D,I.
    reset = 1; idle(1); reset = 0;
    base_i = n_irv; base_d = n_drv; base_b = n_both_rv;
    inst_req = 1; inst_addr = 16'h0040; data_req = 1; data_addr = 16'h0080; data_we = 0;
    iseq = '0; dseq = '0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      iseq = {iseq[4:0], obs_ig};
      dseq = {dseq[4:0], obs_dg};
    end
    idle(3);
    chk("t3_data_grants", 64'(dseq), 64'(6'b101010));
    chk("t3_inst_grants", 64'(iseq), 64'(6'b010101));
    chk("t3_inst_rvalids", 64'(n_irv - base_i), 64'(3));
    chk("t3_data_rvalids", 64'(n_drv - base_d), 64'(3));
    chk("t3_both_rvalid", 64'(n_both_rv - base_b), 64'(0));

    // Reset one cycle after a data grant kills the response and re-arms DATA priority.
    base_i = n_irv; base_d = n_drv;
    dread(16'h0020);
    reset = 1; idle(1); reset = 0;
    idle(3);
    chk("t5_no_rvalid", 64'((n_irv - base_i) + (n_drv - base_d)), 64'(0));
    inst_req = 1; inst_addr = 16'h0044; data_req = 1; data_addr = 16'h0084; data_we = 0;
    cycle();
    chk("t5_contention_winner", 64'({obs_ig, obs_dg}), 64'(2'b01));
    idle(3);

    // Misaligned fetch, then a fetch withdrawn while the LSU holds the port.
    inst_req = 1; inst_addr = 16'h0013; data_req = 0;
    cycle();
    chk("t6_misaligned_addr", 64'(obs_addr), 64'(14'h004));
    idle(3);
    base_i = n_irv;
    inst_req = 1; inst_addr = 16'h0013; data_req = 1; data_addr = 16'h0050; data_we = 0;
    cycle();
    chk("t6_data_wins", 64'({obs_ig, obs_dg}), 64'(2'b01));
    inst_req = 0; data_req = 0;
    cycle();
    chk("t6_dropped_gnt", 64'(obs_ig), 64'(0));
    idle(3);
    chk("t6_no_inst_rvalid", 64'(n_irv - base_i), 64'(0));

    // Table vectors from a fresh reset.
    reset = 1; idle(1); reset = 0;
    for (int i = 0; i < 8; i++) begin
      inst_req = vecs[i].ireq; inst_addr = vecs[i].iaddr;
      data_req = vecs[i].dreq; data_addr = vecs[i].daddr; data_we = vecs[i].we;
      data_be = vecs[i].be; data_wdata = vecs[i].wdata;
      cycle();
      chk($sformatf("vec%0d_gnt", i), 64'({obs_ig, obs_dg}), 64'({vecs[i].ig, vecs[i].dg}));
      chk($sformatf("vec%0d_addr", i), 64'(obs_addr), 64'(vecs[i].addr));
      chk($sformatf("vec%0d_we", i), 64'(obs_we), 64'(vecs[i].bwe));
    end
    idle(3);

    // Random traffic: requesters hold until granted, occasionally withdraw; rare resets.
    got_i = 1; got_d = 1;
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      if (!inst_req || got_i || $urandom_range(0, 9) == 0) begin
        inst_req = ($urandom_range(0, 2) != 0);
        inst_addr = 16'($urandom_range(0, 255));
      end
      if (!data_req || got_d || $urandom_range(0, 9) == 0) begin
        data_req = ($urandom_range(0, 2) != 0);
        data_addr = 16'($urandom_range(0, 255));
        data_we = $urandom_range(0, 1) == 1;
        data_be = 4'($urandom_range(0, 15));
        data_wdata = $urandom;
      end
      cycle();
      got_i = obs_ig; got_d = obs_dg;
    end
    reset = 0;
    idle(4);
    chk("final_queue_empty", 64'(pq.size()), 64'(0));
    chk("random_both_rvalid", 64'(n_both_rv), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
